transparency_fade_blender: RTL and testbench
============================================

// Module: transparency_fade_blender
// PURPOSE
// - Multi-channel alpha blender for the pixel pipeline: out = (a*pA + b*(2^P - pA)) >> P, per channel.
// - Unlike the single-channel combinational blend, the proportion range includes 100% (pA = 2^P).
// - The datapath is registered, with a 2-cycle latency.
// - Adds a frame-synchronous fade engine that ramps the proportion toward a target, one step per N frames.
// - Sits between the overlay source mux and the output formatter; the proportion only changes on frame_start, so there is no tearing.
// PARAMETERS
// - CHANNELS                3   number of colour channels packed in each pixel bus
// - CHANNEL_WIDTH           6   bits per channel
// - TRANSPARENCY_PRECISION  3   P; proportion scale is 2^P; proportion registers are P+1 bits
// - FADE_FRAMES_PER_STEP    2   frames per +/-1 proportion step (>=1)
// PORTS
// - clk              in   1                  pixel clock
// - rst_n            in   1                  async active-low reset
// - frame_start      in   1                  1-cycle pulse at start of each frame
// - pixel_valid_in   in   1                  src_a_in/src_b_in valid this cycle
// - src_a_in         in   CHANNELS*CHANNEL_WIDTH  source A pixel; channel 0 in LSBs
// - src_b_in         in   CHANNELS*CHANNEL_WIDTH  source B pixel
// - fade_start       in   1                  1-cycle pulse: begin fade to fade_target
// - fade_target      in   P+1                target proportion of A; values >2^P are clamped to 2^P
// - pixel_valid_out  out  1                  pixel_valid_in delayed 2 cycles
// - pixel_out        out  CHANNELS*CHANNEL_WIDTH  blended pixel
// - proportion_out   out  P+1                active proportion used by the datapath
// - fade_busy        out  1                  high while the fade engine is not in IDLE
// - fade_done        out  1                  1-cycle pulse when current reaches target
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0.
//   - current and active proportion = 0 (100% B).
//   - Frame counter = 0; state = IDLE.
//   - The pipeline is flushed; an in-flight valid is dropped.
// - Datapath:
//   - Stage 1 registers per-channel products a*pA and b*(2^P-pA).
//   - Stage 2 registers the sum >> P.
//   - Sum width is CHANNEL_WIDTH+P+1; the result never exceeds 2^W-1, so no saturation.
//   - No backpressure; data regs load only when valid, valid always shifts.
// - Proportion:
//   - The datapath uses active_proportion only.
//   - On frame_start, active <= the current value after that edge's fade step.
// - Fade FSM:
//   - States: IDLE, FADE_UP, FADE_DOWN.
//   - fade_start (any state):
//     - latch the clamped target and clear the frame counter;
//     - if target > current -> FADE_UP; if target < current -> FADE_DOWN;
//     - if target == current -> IDLE, with fade_done pulsed the next cycle.
//   - In FADE_*, on each frame_start:
//     - if counter == FADE_FRAMES_PER_STEP-1: current +/- 1 and counter <= 0; otherwise counter++.
//     - When current reaches target -> IDLE and fade_done pulses 1 cycle later.
// - Simultaneous fade_start and frame_start:
//   - fade_start wins: no step that edge and the counter clears.
//   - active still loads the unchanged current value.
// - Retarget mid-fade: direction is recomputed from current; no overshoot.
//   - Example: current=5 FADE_UP to 8, retarget 2 -> FADE_DOWN from 5.
// - Reset mid-fade: the fade is abandoned; no fade_done.
// CONFIGURATION
// - TRANSPARENCY_ROUND_EN defined:
//   - stage 2 computes (sum + 2^(P-1)) >> P (round half up);
//   - the result still never exceeds 2^W-1.
// - Not defined: truncation, (sum >> P).
// TESTING (P=3, W=6, CHANNELS=3, FADE_FRAMES_PER_STEP=2)
// - Reset, then valid pixel a=63 b=0 with active=0 -> pixel_out=0 on all channels, 2 cycles after valid.
// - Set active=4 via fade_start(4) + frame_starts; a=63 b=63 -> 63.
//   - a=63 b=0 -> 31 without TRANSPARENCY_ROUND_EN; 32 with it.
// - fade_start(8) from 0 -> busy for 16 frame_starts, active=8 after the 16th.
//   - fade_done pulses once; then a=63 b=0 -> 63 (100% A).
// - FADE_UP to 8, retarget 2 when current=5:
//   - proportion_out goes 5,4,3,2 (every 2 frames);
//   - never exceeds 5; fade_done once.
// - fade_start and frame_start on the same cycle -> no step that frame, counter cleared.
// - fade_target=12 -> clamped to 8.
// - rst_n low mid-fade while valid in flight:
//   - all outputs 0 immediately;
//   - no pixel_valid_out for the dropped pixel; no fade_done.

Source files
------------

// File: rtl/transparency_fade_blender.sv
// Multi-channel registered alpha blender with a frame-synchronous proportion fade engine.
// Optional build macro TRANSPARENCY_ROUND_EN selects round-half-up instead of truncation in stage 2.
module transparency_fade_blender #(
    parameter int unsigned CHANNELS               = 3,
    parameter int unsigned CHANNEL_WIDTH          = 6,
    parameter int unsigned TRANSPARENCY_PRECISION = 3,
    parameter int unsigned FADE_FRAMES_PER_STEP   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  frame_start,
    input  logic                                  pixel_valid_in,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0]     src_a_in,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0]     src_b_in,
    input  logic                                  fade_start,
    input  logic [TRANSPARENCY_PRECISION:0]       fade_target,
    output logic                                  pixel_valid_out,
    output logic [CHANNELS*CHANNEL_WIDTH-1:0]     pixel_out,
    output logic [TRANSPARENCY_PRECISION:0]       proportion_out,
    output logic                                  fade_busy,
    output logic                                  fade_done
);

    localparam int unsigned P    = TRANSPARENCY_PRECISION;
    localparam int unsigned PW   = P + 1;
    localparam int unsigned W    = CHANNEL_WIDTH;
    localparam int unsigned SW   = W + P + 1;
    localparam int unsigned PIXW = CHANNELS * W;
    localparam int unsigned CW   = (FADE_FRAMES_PER_STEP > 1) ? $clog2(FADE_FRAMES_PER_STEP) : 1;

    localparam logic [PW-1:0] SCALE    = {1'b1, {P{1'b0}}};
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES_PER_STEP - 1);
`ifdef TRANSPARENCY_ROUND_EN
    localparam logic [SW-1:0] ROUND_ADD = SW'(1) << (P - 1);
`else
    localparam logic [SW-1:0] ROUND_ADD = '0;
`endif

    typedef enum logic [1:0] {IDLE, FADE_UP, FADE_DOWN} fade_state_t;

    fade_state_t     state, state_n;
    logic [PW-1:0]   current, current_n;
    logic [PW-1:0]   target, target_n;
    logic [PW-1:0]   active, active_n;
    logic [PW-1:0]   clamped;
    logic [CW-1:0]   frame_cnt, frame_cnt_n;
    logic            done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            current   <= '0;
            target    <= '0;
            active    <= '0;
            frame_cnt <= '0;
            fade_done <= 1'b0;
        end else begin
            state     <= state_n;
            current   <= current_n;
            target    <= target_n;
            active    <= active_n;
            frame_cnt <= frame_cnt_n;
            fade_done <= done_n;
        end
    end

    // fade_start takes priority over a coincident frame step; active still
    // samples the (then unchanged) current value on frame_start.
    always_comb begin
        state_n     = state;
        current_n   = current;
        target_n    = target;
        frame_cnt_n = frame_cnt;
        done_n      = 1'b0;
        clamped     = (fade_target > SCALE) ? SCALE : fade_target;
        if (fade_start) begin
            target_n    = clamped;
            frame_cnt_n = '0;
            if (clamped > current) begin
                state_n = FADE_UP;
            end else if (clamped < current) begin
                state_n = FADE_DOWN;
            end else begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else if (frame_start && (state != IDLE)) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt_n = '0;
                current_n   = (state == FADE_UP) ? current + P_ONE : current - P_ONE;
                if (current_n == target) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end else begin
                frame_cnt_n = frame_cnt + CNT_ONE;
            end
        end
        active_n = frame_start ? current_n : active;
    end

    assign proportion_out = active;
    assign fade_busy      = (state != IDLE);

    logic [SW-1:0]   prod_a   [CHANNELS];
    logic [SW-1:0]   prod_b   [CHANNELS];
    logic [SW-1:0]   prod_a_n [CHANNELS];
    logic [SW-1:0]   prod_b_n [CHANNELS];
    logic [SW-1:0]   sum      [CHANNELS];
    logic [PIXW-1:0] pixel_n;
    logic            valid_s1;

    always_comb begin
        pixel_n = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            prod_a_n[c] = SW'(src_a_in[c*W +: W]) * SW'(active);
            prod_b_n[c] = SW'(src_b_in[c*W +: W]) * SW'(SCALE - active);
            sum[c]      = prod_a[c] + prod_b[c] + ROUND_ADD;
            pixel_n[c*W +: W] = W'(sum[c] >> P);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1        <= 1'b0;
            pixel_valid_out <= 1'b0;
            pixel_out       <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                prod_a[c] <= '0;
                prod_b[c] <= '0;
            end
        end else begin
            valid_s1        <= pixel_valid_in;
            pixel_valid_out <= valid_s1;
            if (pixel_valid_in) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    prod_a[c] <= prod_a_n[c];
                    prod_b[c] <= prod_b_n[c];
                end
            end
            if (valid_s1) begin
                pixel_out <= pixel_n;
            end
        end
    end

endmodule

// File: tb/tb_transparency_fade_blender.sv
// Directed self-checking bench for transparency_fade_blender (P=3, W=6, 3 channels, 2 frames/step).
module tb_transparency_fade_blender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pixel_valid_in;
    logic [17:0] src_a_in;
    logic [17:0] src_b_in;
    logic        fade_start;
    logic [3:0]  fade_target;
    logic        pixel_valid_out;
    logic [17:0] pixel_out;
    logic [3:0]  proportion_out;
    logic        fade_busy;
    logic        fade_done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int vout_cnt = 0;

    transparency_fade_blender #(
        .CHANNELS(3),
        .CHANNEL_WIDTH(6),
        .TRANSPARENCY_PRECISION(3),
        .FADE_FRAMES_PER_STEP(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .pixel_valid_in(pixel_valid_in),
        .src_a_in(src_a_in),
        .src_b_in(src_b_in),
        .fade_start(fade_start),
        .fade_target(fade_target),
        .pixel_valid_out(pixel_valid_out),
        .pixel_out(pixel_out),
        .proportion_out(proportion_out),
        .fade_busy(fade_busy),
        .fade_done(fade_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fade_done === 1'b1) done_cnt++;
        if (pixel_valid_out === 1'b1) vout_cnt++;
    end

    function automatic logic [17:0] pack(input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        frame_start = 1'b0; pixel_valid_in = 1'b0; fade_start = 1'b0;
        src_a_in = '0; src_b_in = '0; fade_target = '0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
    endtask

    task automatic start_fade(input logic [3:0] t);
        fade_target = t;
        fade_start = 1'b1;
        tick;
        fade_start = 1'b0;
    endtask

    task automatic drive_pixel(input logic [17:0] a, input logic [17:0] b);
        src_a_in = a; src_b_in = b; pixel_valid_in = 1'b1;
        tick;
        pixel_valid_in = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        frame_start = 1'b0; pixel_valid_in = 1'b0; fade_start = 1'b0;
        src_a_in = '0; src_b_in = '0; fade_target = '0;
        tick; tick;
        n_cmp++; if (pixel_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", pixel_valid_out); end
        n_cmp++; if (pixel_out !== 18'd0) begin n_err++; $display("FAIL reset_pixel: got %h expected 0", pixel_out); end
        n_cmp++; if (proportion_out !== 4'd0) begin n_err++; $display("FAIL reset_prop: got %0d expected 0", proportion_out); end
        n_cmp++; if ({fade_busy, fade_done} !== 2'b00) begin n_err++; $display("FAIL reset_fade: got %b expected 00", {fade_busy, fade_done}); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_zero_prop;
        src_a_in = pack(63, 63, 63); src_b_in = '0; pixel_valid_in = 1'b1;
        tick;
        pixel_valid_in = 1'b0;
        n_cmp++; if (pixel_valid_out !== 1'b0) begin n_err++; $display("FAIL zero_lat1: got %b expected 0", pixel_valid_out); end
        tick;
        n_cmp++; if (pixel_valid_out !== 1'b1) begin n_err++; $display("FAIL zero_lat2: got %b expected 1", pixel_valid_out); end
        n_cmp++; if (pixel_out !== 18'd0) begin n_err++; $display("FAIL zero_pixel: got %h expected 0", pixel_out); end
        tick;
        n_cmp++; if (pixel_valid_out !== 1'b0) begin n_err++; $display("FAIL zero_pulse: got %b expected 0", pixel_valid_out); end
    endtask

    task automatic test_half;
        logic [17:0] exp;
        int d0;
        d0 = done_cnt;
        start_fade(4'd4);
        n_cmp++; if (fade_busy !== 1'b1) begin n_err++; $display("FAIL half_busy: got %b expected 1", fade_busy); end
        repeat (8) frame;
        n_cmp++; if (proportion_out !== 4'd4) begin n_err++; $display("FAIL half_prop: got %0d expected 4", proportion_out); end
        n_cmp++; if (fade_busy !== 1'b0) begin n_err++; $display("FAIL half_idle: got %b expected 0", fade_busy); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL half_done: got %0d expected 1", done_cnt - d0); end
        drive_pixel(pack(63, 63, 63), pack(63, 63, 63));
        n_cmp++; if (pixel_out !== pack(63, 63, 63)) begin n_err++; $display("FAIL half_same: got %h expected %h", pixel_out, pack(63, 63, 63)); end
`ifdef TRANSPARENCY_ROUND_EN
        exp = pack(32, 24, 32);
`else
        exp = pack(31, 24, 32);
`endif
        drive_pixel(pack(63, 40, 1), pack(0, 8, 63));
        n_cmp++; if (pixel_out !== exp) begin n_err++; $display("FAIL half_mix: got %h expected %h", pixel_out, exp); end
    endtask

    task automatic test_fade_full;
        int d0;
        int n;
        do_reset;
        d0 = done_cnt;
        start_fade(4'd8);
        n_cmp++; if (fade_busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b expected 1", fade_busy); end
        frame;
        n_cmp++; if (proportion_out !== 4'd0) begin n_err++; $display("FAIL full_f1: got %0d expected 0", proportion_out); end
        frame;
        n_cmp++; if (proportion_out !== 4'd1) begin n_err++; $display("FAIL full_f2: got %0d expected 1", proportion_out); end
        n = 2;
        while (fade_busy === 1'b1 && n < 40) begin frame; n++; end
        n_cmp++; if (n != 16) begin n_err++; $display("FAIL full_frames: got %0d expected 16", n); end
        n_cmp++; if (proportion_out !== 4'd8) begin n_err++; $display("FAIL full_prop: got %0d expected 8", proportion_out); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL full_done: got %0d expected 1", done_cnt - d0); end
        drive_pixel(pack(63, 20, 5), pack(0, 50, 60));
        n_cmp++; if (pixel_out !== pack(63, 20, 5)) begin n_err++; $display("FAIL full_pixel: got %h expected %h", pixel_out, pack(63, 20, 5)); end
    endtask

    task automatic test_retarget;
        logic [3:0] exp_seq [6];
        int d0;
        int n;
        logic [3:0] maxp;
        exp_seq = '{4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2};
        do_reset;
        start_fade(4'd8);
        n = 0;
        while (proportion_out !== 4'd5 && n < 40) begin frame; n++; end
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL retarget_reach5: got %0d expected 10", n); end
        d0 = done_cnt;
        start_fade(4'd2);
        n_cmp++; if (fade_busy !== 1'b1) begin n_err++; $display("FAIL retarget_busy: got %b expected 1", fade_busy); end
        maxp = proportion_out;
        for (int i = 0; i < 6; i++) begin
            frame;
            if (proportion_out > maxp) maxp = proportion_out;
            n_cmp++; if (proportion_out !== exp_seq[i]) begin n_err++; $display("FAIL retarget_seq%0d: got %0d expected %0d", i, proportion_out, exp_seq[i]); end
        end
        n_cmp++; if (maxp > 4'd5) begin n_err++; $display("FAIL retarget_max: got %0d expected <=5", maxp); end
        n_cmp++; if (fade_busy !== 1'b0) begin n_err++; $display("FAIL retarget_idle: got %b expected 0", fade_busy); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL retarget_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_simultaneous;
        do_reset;
        start_fade(4'd8);
        frame;
        fade_target = 4'd8; fade_start = 1'b1; frame_start = 1'b1;
        tick;
        fade_start = 1'b0; frame_start = 1'b0;
        tick;
        n_cmp++; if (proportion_out !== 4'd0) begin n_err++; $display("FAIL simul_nostep: got %0d expected 0", proportion_out); end
        frame;
        n_cmp++; if (proportion_out !== 4'd0) begin n_err++; $display("FAIL simul_cleared: got %0d expected 0", proportion_out); end
        frame;
        n_cmp++; if (proportion_out !== 4'd1) begin n_err++; $display("FAIL simul_step: got %0d expected 1", proportion_out); end
    endtask

    task automatic test_clamp;
        int d0;
        int n;
        do_reset;
        start_fade(4'd12);
        n = 0;
        while (fade_busy === 1'b1 && n < 40) begin frame; n++; end
        n_cmp++; if (n != 16) begin n_err++; $display("FAIL clamp_frames: got %0d expected 16", n); end
        n_cmp++; if (proportion_out !== 4'd8) begin n_err++; $display("FAIL clamp_prop: got %0d expected 8", proportion_out); end
        d0 = done_cnt;
        start_fade(4'd15);
        tick;
        n_cmp++; if (fade_busy !== 1'b0) begin n_err++; $display("FAIL clamp_equal_busy: got %b expected 0", fade_busy); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL clamp_equal_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        int d0;
        int v0;
        do_reset;
        start_fade(4'd8);
        frame; frame;
        n_cmp++; if (proportion_out !== 4'd1) begin n_err++; $display("FAIL rstmid_pre: got %0d expected 1", proportion_out); end
        d0 = done_cnt;
        v0 = vout_cnt;
        src_a_in = pack(63, 63, 63); src_b_in = pack(7, 7, 7); pixel_valid_in = 1'b1;
        tick;
        pixel_valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({pixel_valid_out, fade_busy, fade_done} !== 3'b000) begin n_err++; $display("FAIL rstmid_ctrl: got %b expected 000", {pixel_valid_out, fade_busy, fade_done}); end
        n_cmp++; if (pixel_out !== 18'd0) begin n_err++; $display("FAIL rstmid_pixel: got %h expected 0", pixel_out); end
        n_cmp++; if (proportion_out !== 4'd0) begin n_err++; $display("FAIL rstmid_prop: got %0d expected 0", proportion_out); end
        tick; tick;
        rst_n = 1'b1;
        repeat (4) tick;
        n_cmp++; if (vout_cnt != v0) begin n_err++; $display("FAIL rstmid_dropped: got %0d expected %0d", vout_cnt, v0); end
        n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL rstmid_nodone: got %0d expected %0d", done_cnt, d0); end
        n_cmp++; if (fade_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b expected 0", fade_busy); end
    endtask

    initial begin
        test_reset;
        test_zero_prop;
        test_half;
        test_fade_full;
        test_retarget;
        test_simultaneous;
        test_clamp;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
